// File: rtl/main_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_arbiter_pkg
// Purpose  : Shared types for the main-memory arbiter: block address and block
//            data types, FSM state encoding and the requester/owner encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package main_mem_arbiter_pkg;

    localparam int MAIN_MEM_ADDR_WIDTH         = 32;
    localparam int MAIN_MEM_BLOCK_OFFSET_WIDTH = 4;
    localparam int BLOCK_DATA_WIDTH            = 128;
    localparam int MAIN_MEM_BLOCK_ADDR_WIDTH   = MAIN_MEM_ADDR_WIDTH - MAIN_MEM_BLOCK_OFFSET_WIDTH;

    typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/main_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-requester round-robin grant. A lone requester always wins; on
//            a tie the requester that did not win last time is granted.
// Ports    : i_icache_req / i_dcache_req - request lines
//            i_last_grant                - owner of the previous grant
//            o_grant_valid               - some requester is granted
//            o_grant_owner               - granted requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import main_mem_arbiter_pkg::*;
(
    input  logic   i_icache_req,
    input  logic   i_dcache_req,
    input  owner_t i_last_grant,
    output logic   o_grant_valid,
    output owner_t o_grant_owner
);

    always_comb begin
        o_grant_valid = i_icache_req | i_dcache_req;
        o_grant_owner = OWNER_ICACHE;
        if (i_icache_req && i_dcache_req) begin
            o_grant_owner = (i_last_grant == OWNER_DCACHE) ? OWNER_ICACHE : OWNER_DCACHE;
        end else if (i_dcache_req) begin
            o_grant_owner = OWNER_DCACHE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_arbiter
// Purpose  : Arbitrates I-cache fills and D-cache fills/write-backs onto a
//            single main-memory port with one transaction outstanding.
// Ports    : clk, rst                    - clock, sync active-high reset
//            icache_req_* / icache_resp_* - I-cache fill request/response
//            dcache_req_* / dcache_resp_* - D-cache request/response
//            mem_req_* / mem_resp_*       - main-memory request/response
//            mem_err                      - sticky timeout / spurious-response
// Revision : 1.0 - initial release
// ============================================================================
module main_mem_arbiter
    import main_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 icache_req_valid,
    input  main_mem_block_addr_t icache_req_block_addr,
    output logic                 icache_req_ready,
    output logic                 icache_resp_valid,
    output block_data_t          icache_resp_block_data,
    input  logic                 dcache_req_valid,
    input  logic                 dcache_req_wr,
    input  main_mem_block_addr_t dcache_req_block_addr,
    input  block_data_t          dcache_req_block_data,
    output logic                 dcache_req_ready,
    output logic                 dcache_resp_valid,
    output block_data_t          dcache_resp_block_data,
    output logic                 mem_req_valid,
    output logic                 mem_req_wr,
    output main_mem_block_addr_t mem_req_block_addr,
    output block_data_t          mem_req_block_data,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  block_data_t          mem_resp_block_data,
    output logic                 mem_err
);

    localparam int                 C_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    arb_state_t           r_state;
    owner_t               r_owner;
    owner_t               r_last_grant;
    main_mem_block_addr_t r_addr;
    logic                 r_wr;
    block_data_t          r_data;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_err;

    logic               w_grant_valid;
    owner_t             w_grant_owner;
    logic               w_idle;
    logic               w_accept;
    logic               w_resp_ok;
    logic [C_CNT_W-1:0] w_cnt_next;

    rr_arbiter2 u_rr_arbiter2 (
        .i_icache_req  (icache_req_valid),
        .i_dcache_req  (dcache_req_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_owner (w_grant_owner)
    );

    assign w_idle           = (r_state == IDLE);
    assign icache_req_ready = w_idle && w_grant_valid && (w_grant_owner == OWNER_ICACHE);
    assign dcache_req_ready = w_idle && w_grant_valid && (w_grant_owner == OWNER_DCACHE);
    assign w_accept         = (icache_req_valid && icache_req_ready) ||
                              (dcache_req_valid && dcache_req_ready);

    // Request fields are only presented while the request is being offered,
    // so the memory side sees zeros whenever nothing is outstanding.
    assign mem_req_valid      = (r_state == ISSUE);
    assign mem_req_wr         = mem_req_valid && r_wr;
    assign mem_req_block_addr = mem_req_valid ? r_addr : '0;
    assign mem_req_block_data = mem_req_valid ? r_data : '0;

    // Response is a same-cycle pass-through to whichever requester owns the
    // outstanding transaction; data is zeroed when no pulse is given.
    assign w_resp_ok              = (r_state == WAIT_RESP) && mem_resp_valid;
    assign icache_resp_valid      = w_resp_ok && (r_owner == OWNER_ICACHE);
    assign dcache_resp_valid      = w_resp_ok && (r_owner == OWNER_DCACHE);
    assign icache_resp_block_data = icache_resp_valid ? mem_resp_block_data : '0;
    assign dcache_resp_block_data = dcache_resp_valid ? mem_resp_block_data : '0;

    assign w_cnt_next = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);
    assign mem_err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_ICACHE;
            r_last_grant <= OWNER_DCACHE;   // I-cache wins the first tie
            r_addr       <= '0;
            r_wr         <= 1'b0;
            r_data       <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            // Any response we are not waiting for is spurious.
            if (mem_resp_valid && (r_state != WAIT_RESP)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant_owner;
                        r_last_grant <= w_grant_owner;
                        r_state      <= ISSUE;
                        if (w_grant_owner == OWNER_DCACHE) begin
                            r_addr <= dcache_req_block_addr;
                            r_wr   <= dcache_req_wr;
                            r_data <= dcache_req_block_data;
                        end else begin
                            r_addr <= icache_req_block_addr;
                            r_wr   <= 1'b0;
                            r_data <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        r_state <= WAIT_RESP;
                        r_cnt   <= '0;
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        r_state <= IDLE;
                    end else begin
                        // Flag the timeout but keep waiting for a late reply.
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == C_CNT_MAX) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_mem_arbiter
// Purpose  : Self-checking bench for main_mem_arbiter: directed scenarios
//            followed by randomized traffic against a transaction-level model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_mem_arbiter;
    import main_mem_arbiter_pkg::*;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_v = 1'b0;
    logic [27:0]  ic_addr = '0;
    logic         ic_rdy, ic_rv;
    logic [127:0] ic_rdata;
    logic         dc_v = 1'b0, dc_wr = 1'b0;
    logic [27:0]  dc_addr = '0;
    logic [127:0] dc_data = '0;
    logic         dc_rdy, dc_rv;
    logic [127:0] dc_rdata;
    logic         m_rv_out, m_wr_out;
    logic [27:0]  m_addr_out;
    logic [127:0] m_data_out;
    logic         mem_rdy = 1'b0, mem_rv = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         err;

    main_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .icache_req_valid       (ic_v),
        .icache_req_block_addr  (ic_addr),
        .icache_req_ready       (ic_rdy),
        .icache_resp_valid      (ic_rv),
        .icache_resp_block_data (ic_rdata),
        .dcache_req_valid       (dc_v),
        .dcache_req_wr          (dc_wr),
        .dcache_req_block_addr  (dc_addr),
        .dcache_req_block_data  (dc_data),
        .dcache_req_ready       (dc_rdy),
        .dcache_resp_valid      (dc_rv),
        .dcache_resp_block_data (dc_rdata),
        .mem_req_valid          (m_rv_out),
        .mem_req_wr             (m_wr_out),
        .mem_req_block_addr     (m_addr_out),
        .mem_req_block_data     (m_data_out),
        .mem_req_ready          (mem_rdy),
        .mem_resp_valid         (mem_rv),
        .mem_resp_block_data    (mem_rdata),
        .mem_err                (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: one open transaction, its owner and fields,
    // whether memory took it, and how long we have waited for the reply.
    bit           m_open, m_sent, m_err, m_wr;
    int           m_owner, m_last, m_wait, m_issue;
    logic [27:0]  m_addr;
    logic [127:0] m_data;
    int           dut_grants[$];

    int           rdy_lat, resp_lat;
    logic [127:0] resp_data;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        int g;
        bit e_irv, e_drv, e_mv;
        g = -1;
        #1;
        if (!rst) begin
            if (!m_open) begin
                if (ic_v && dc_v) g = (m_last == 1) ? 0 : 1;
                else if (ic_v)    g = 0;
                else if (dc_v)    g = 1;
            end
            e_mv  = m_open && !m_sent;
            e_irv = m_open && m_sent && mem_rv && (m_owner == 0);
            e_drv = m_open && m_sent && mem_rv && (m_owner == 1);
            check_val("icache_req_ready", ic_rdy, g == 0);
            check_val("dcache_req_ready", dc_rdy, g == 1);
            check_val("mem_req_valid", m_rv_out, e_mv);
            check_val("mem_req_wr", m_wr_out, e_mv && m_wr);
            check_val("mem_req_addr", m_addr_out, e_mv ? m_addr : 28'h0);
            if (e_mv && m_wr) check_val("mem_req_data", m_data_out, m_data);
            check_val("icache_resp_valid", ic_rv, e_irv);
            check_val("dcache_resp_valid", dc_rv, e_drv);
            if (e_irv) check_val("icache_resp_data", ic_rdata, mem_rdata);
            if (e_drv && !m_wr) check_val("dcache_resp_data", dc_rdata, mem_rdata);
            check_val("mem_err", err, m_err);
            if (ic_v && ic_rdy) dut_grants.push_back(0);
            if (dc_v && dc_rdy) dut_grants.push_back(1);
        end
        @(posedge clk);
        if (rst) begin
            m_open = 0; m_sent = 0; m_err = 0; m_last = 1; m_wait = 0; m_issue = 0;
        end else begin
            if (mem_rv && !(m_open && m_sent)) m_err = 1;
            if (!m_open) begin
                if (g >= 0) begin
                    m_open  = 1;
                    m_sent  = 0;
                    m_owner = g;
                    m_last  = g;
                    m_issue = 0;
                    m_addr  = (g == 1) ? dc_addr : ic_addr;
                    m_wr    = (g == 1) ? dc_wr : 1'b0;
                    m_data  = (g == 1) ? dc_data : 128'h0;
                end
            end else if (!m_sent) begin
                if (mem_rdy) begin m_sent = 1; m_wait = 0; end
                else m_issue++;
            end else begin
                if (mem_rv) m_open = 0;
                else begin
                    m_wait++;
                    if (m_wait >= TMO) m_err = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_mem();
        mem_rdy   = m_open && !m_sent && (m_issue >= rdy_lat);
        mem_rv    = m_open && m_sent && (m_wait >= resp_lat);
        mem_rdata = resp_data;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_mem();
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1; ic_v = 0; dc_v = 0; dc_wr = 0; mem_rdy = 0; mem_rv = 0;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        rdy_lat = 0; resp_lat = 0; resp_data = '0;
        @(negedge clk);

        // Reset state
        do_reset();
        #1;
        check_val("rst_ic_ready", ic_rdy, 0);
        check_val("rst_mem_req_valid", m_rv_out, 0);
        check_val("rst_mem_addr", m_addr_out, 0);
        check_val("rst_mem_err", err, 0);
        tick();

        // I-cache fill, memory ready at once, reply on the 3rd wait cycle
        do_reset();
        ic_v = 1; ic_addr = 28'(32'h1018c >> MAIN_MEM_BLOCK_OFFSET_WIDTH);
        rdy_lat = 0; resp_lat = 2; resp_data = {16{8'hA5}};
        drive_mem(); #1;
        check_val("A_ic_ready", ic_rdy, 1);
        tick();
        ic_v = 0;
        drive_mem(); #1;
        check_val("A_mem_req_valid", m_rv_out, 1);
        check_val("A_mem_req_wr", m_wr_out, 0);
        check_val("A_mem_req_addr", m_addr_out, 28'h1018);
        tick();
        run(2);
        drive_mem(); #1;
        check_val("A_resp_valid", ic_rv, 1);
        check_val("A_resp_data", ic_rdata, {16{8'hA5}});
        tick();
        ic_v = 1;
        drive_mem(); #1;
        check_val("A_resp_pulse_end", ic_rv, 0);
        check_val("A_next_accept", ic_rdy, 1);
        tick();
        ic_v = 0;
        run(6);

        // Tie right after reset, then alternation while both are held
        do_reset();
        dut_grants.delete();
        ic_v = 1; dc_v = 1; rdy_lat = 0; resp_lat = 1; resp_data = 128'h55;
        drive_mem(); #1;
        check_val("B_tie_ic_ready", ic_rdy, 1);
        check_val("B_tie_dc_ready", dc_rdy, 0);
        tick();
        run(15);
        ic_v = 0; dc_v = 0;
        run(4);
        check_val("B_grant_count", dut_grants.size() >= 4, 1);
        if (dut_grants.size() >= 4) begin
            check_val("B_grant1_dcache", dut_grants[1], 1);
            check_val("B_grant2_icache", dut_grants[2], 0);
            check_val("B_grant3_dcache", dut_grants[3], 1);
        end

        // D-cache write-back with a slow memory accept
        do_reset();
        dc_v = 1; dc_wr = 1; dc_addr = 28'h40;
        dc_data = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        rdy_lat = 5; resp_lat = 0; resp_data = '0;
        run(1);
        dc_v = 0; dc_wr = 0; dc_addr = 28'h0abcdef; dc_data = {4{32'hdeadbeef}};
        for (int i = 0; i < 5; i++) begin
            drive_mem(); #1;
            check_val("C_hold_valid", m_rv_out, 1);
            check_val("C_hold_wr", m_wr_out, 1);
            check_val("C_hold_addr", m_addr_out, 28'h40);
            check_val("C_hold_data", m_data_out, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
            tick();
        end
        run(1);
        drive_mem(); #1;
        check_val("C_wr_ack", dc_rv, 1);
        check_val("C_wr_ack_ic_quiet", ic_rv, 0);
        tick();
        run(2);

        // Timeout with a late reply
        do_reset();
        ic_v = 1; ic_addr = 28'h123; rdy_lat = 0; resp_lat = 1000; resp_data = 128'hbeef;
        run(1);
        ic_v = 0;
        run(1);
        for (int w = 1; w <= TMO; w++) begin
            drive_mem(); #1;
            check_val("D_err_low", err, 0);
            tick();
        end
        drive_mem(); #1;
        check_val("D_err_high", err, 1);
        tick();
        mem_rdy = 0; mem_rv = 1; mem_rdata = 128'hcafe; #1;
        check_val("D_late_resp", ic_rv, 1);
        tick();
        mem_rv = 0; #1;
        check_val("D_err_sticky", err, 1);
        tick();

        // Spurious reply in IDLE, then reset during WAIT_RESP
        do_reset();
        mem_rv = 1; mem_rdata = 128'h77; #1;
        check_val("E_spur_ic_quiet", ic_rv, 0);
        check_val("E_spur_dc_quiet", dc_rv, 0);
        tick();
        mem_rv = 0; #1;
        check_val("E_spur_err", err, 1);
        tick();
        do_reset();
        ic_v = 1; rdy_lat = 0; resp_lat = 1000;
        run(1);
        ic_v = 0;
        run(2);
        rst = 1;
        drive_mem();
        tick();
        rst = 0; mem_rdy = 0; mem_rv = 0; #1;
        check_val("E_rst_mem_valid", m_rv_out, 0);
        check_val("E_rst_ic_resp", ic_rv, 0);
        check_val("E_rst_err", err, 0);
        tick();
        mem_rv = 1; #1;
        check_val("E_late_after_rst", ic_rv, 0);
        tick();
        mem_rv = 0; #1;
        check_val("E_late_err", err, 1);
        tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 149) == 0);
            ic_v    = $urandom_range(0, 1);
            dc_v    = $urandom_range(0, 1);
            dc_wr   = $urandom_range(0, 1);
            ic_addr = 28'($urandom);
            dc_addr = 28'($urandom);
            dc_data = {$urandom, $urandom, $urandom, $urandom};
            mem_rdy = m_open && !m_sent && ($urandom_range(0, 2) == 0);
            mem_rv  = (m_open && m_sent) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 63) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT_RESP cycles before the timeout error flag sets.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 icache_req_valid  input  1  I-cache block-fill request.
REQ-005 icache_req_block_addr  input  main_mem_block_addr_t  block address of fill.
REQ-006 icache_req_ready  output  1  I-cache request accepted this cycle.
REQ-007 icache_resp_valid  output  1  one-cycle pulse, fill data valid.
REQ-008 icache_resp_block_data  output  block_data_t  fill data.
REQ-009 dcache_req_valid / dcache_req_wr  input  1 / 1  D-cache request valid; 1 = write-back, 0 = fill.
REQ-010 dcache_req_block_addr / dcache_req_block_data  input  main_mem_block_addr_t / block_data_t  address; write data.
REQ-011 dcache_req_ready / dcache_resp_valid  output  1 / 1  accept; one-cycle response pulse (reads and writes).
REQ-012 dcache_resp_block_data  output  block_data_t  read data; don't-care on write ack.
REQ-013 mem_req_valid / mem_req_wr  output  1 / 1  request to main memory; write flag.
REQ-014 mem_req_block_addr / mem_req_block_data  output  main_mem_block_addr_t / block_data_t  latched address and write data.
REQ-015 mem_req_ready  input  1  main memory accepts request.
REQ-016 mem_resp_valid / mem_resp_block_data  input  1 / block_data_t  memory response; every request, including writes, gets exactly one.
REQ-017 mem_err  output  1  sticky: timeout or spurious response.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT_RESP; exactly one transaction outstanding.
REQ-019 In IDLE, grant: one requester valid -> it wins; both valid -> the one not in last_grant wins (round-robin).
REQ-020 *_req_ready is combinational, high only in IDLE for the granted requester; at most one ready per cycle.
REQ-021 On accept (valid & ready): latch addr, wr (0 for I-cache), data, owner; set last_grant = owner; go to ISSUE.
REQ-022 ISSUE: mem_req_valid = 1 with latched fields held stable; on mem_req_ready go to WAIT_RESP and clear the timeout counter.
REQ-023 WAIT_RESP: on mem_resp_valid, drive the owner's resp_valid = 1 in the same cycle, with mem_resp_block_data passed through combinationally; go to IDLE.
REQ-024 Latency: accept in cycle N -> mem_req_valid in N+1. With mem_req_ready in N+1 and response in M, the next accept is possible in M+1.
REQ-025 Timeout counter (width clog2(TIMEOUT_CYCLES+1)) increments each WAIT_RESP cycle without a response; saturates. At TIMEOUT_CYCLES, mem_err sets; FSM keeps waiting.
REQ-026 mem_resp_valid outside WAIT_RESP: ignored (no resp pulse) and mem_err sets.
REQ-027 Requester valid dropped before accept: no effect. Request fields are sampled only at accept.
REQ-028 Non-owner resp_valid is always 0; resp_valid is never high outside WAIT_RESP.

Reset
REQ-029 When rst is high at posedge: state = IDLE, last_grant = dcache (I-cache wins the first tie), counter = 0, mem_err = 0, latched fields = 0.
REQ-030 Reset outputs: all ready/valid outputs 0, mem_err 0, data/address outputs 0.
REQ-031 Reset mid-transaction abandons the transaction: no response pulse, and a later memory response is treated as spurious.

Structure
REQ-032 main_mem_block_addr_t, block_data_t, MAIN_MEM_BLOCK_OFFSET_WIDTH and BLOCK_DATA_WIDTH come from the shared global definitions. The arb_state_t enum and the owner encoding go in the shared package.
REQ-033 A round-robin grant sub-module, rr_arbiter2 (two requesters, last_grant input), is natural; the rest is a single FSM module.

Verification
REQ-034 Only I-cache req, addr 0x1018c>>MAIN_MEM_BLOCK_OFFSET_WIDTH; mem ready immediately; resp 3 cycles later with data 0xA5..A5 -> icache_resp_valid one cycle with that data; mem_req_wr=0.
REQ-035 Both valid in the first cycle after reset -> I-cache granted. Both held continuously -> grants alternate D, I, D over the next 3 transactions.
REQ-036 D-cache write, addr 0x40, data 0x1234...; mem_req_ready held low 5 cycles -> mem_req fields stable all 5 cycles; write ack produces a dcache_resp_valid pulse.
REQ-037 TIMEOUT_CYCLES=4, no response -> mem_err rises after the 4th WAIT_RESP cycle. A late response still pulses the owner, and mem_err stays 1.
REQ-038 mem_resp_valid pulsed in IDLE -> no resp pulse, mem_err=1. rst asserted in WAIT_RESP -> IDLE next cycle, all outputs 0, no pulse.
